three_color_light_ctrl: RTL and testbench

Top-level controller for a three-colour (RGB) indicator LED plus one key-feedback LED. Two push keys are synchronised and debounced. Key[0] steps through a colour sequence; Key[1] steps through four PWM brightness levels. Runs from the 50 MHz system clock; LED outputs drive board pins directly.

---
 rtl/three_color_light_pkg.sv | 41 ++++
 rtl/key_debounce.sv | 49 ++++
 rtl/three_color_light_ctrl.sv | 82 ++++++++
 tb/tb_three_color_light_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/three_color_light_pkg.sv
// Shared types and constants for the RGB indicator controller.
// Colour sequence, colour masks, LED bit positions and brightness level count.
package three_color_light_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_RED   = 3'd1,
    MODE_GREEN = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_WHITE = 3'd4
  } color_mode_t;

  localparam int NUM_LEVELS = 4;

  localparam int LED_RED   = 0;
  localparam int LED_GREEN = 1;
  localparam int LED_BLUE  = 2;
  localparam int LED_KEY   = 3;

  // Mask bit order is {B,G,R}, matching LED[2:0].
  function automatic logic [2:0] mode_mask(input color_mode_t mode);
    case (mode)
      MODE_RED:   return 3'b001;
      MODE_GREEN: return 3'b010;
      MODE_BLUE:  return 3'b100;
      MODE_WHITE: return 3'b111;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic color_mode_t mode_next(input color_mode_t mode);
    case (mode)
      MODE_OFF:   return MODE_RED;
      MODE_RED:   return MODE_GREEN;
      MODE_GREEN: return MODE_BLUE;
      MODE_BLUE:  return MODE_WHITE;
      default:    return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, hold-time debounce, and a one-cycle press pulse
// on each accepted 0->1 of the debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic Sys_CLK,
  input  logic Sys_RST,
  input  logic key_raw,
  output logic key_level,
  output logic key_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync0 <= key_raw;
      r_sync1 <= r_sync0;
      r_press <= 1'b0;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Level held long enough: accept it; only rising acceptances pulse.
        r_cnt   <= '0;
        r_level <= r_sync1;
        r_press <= r_sync1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_level = r_level;
  assign key_press = r_press;

endmodule

// File: rtl/three_color_light_ctrl.sv
// RGB indicator: Key[0] steps the colour, Key[1] steps a 4-level PWM brightness.
// LED[3] mirrors either debounced key; all LED bits are registered.
module three_color_light_ctrl
  import three_color_light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int PWM_PERIOD      = 256
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key,
  output logic [3:0] LED
);

  localparam int PWM_W   = $clog2(PWM_PERIOD);
  localparam int QUARTER = PWM_PERIOD / NUM_LEVELS;
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_PERIOD - 1);

  logic [1:0]       w_key_level;
  logic [1:0]       w_key_press;
  color_mode_t      r_mode;
  color_mode_t      w_mode_nxt;
  logic [1:0]       r_level;
  logic [1:0]       w_level_nxt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W:0]   w_thresh;
  logic             w_pwm_on;
  logic [3:0]       w_led_nxt;
  logic [3:0]       r_led;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_color (
    .Sys_CLK   (Sys_CLK),
    .Sys_RST   (Sys_RST),
    .key_raw   (Key[0]),
    .key_level (w_key_level[0]),
    .key_press (w_key_press[0])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_bright (
    .Sys_CLK   (Sys_CLK),
    .Sys_RST   (Sys_RST),
    .key_raw   (Key[1]),
    .key_level (w_key_level[1]),
    .key_press (w_key_press[1])
  );

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      r_mode    <= MODE_OFF;
      r_level   <= 2'd3;
      r_pwm_cnt <= '0;
      r_led     <= 4'b0000;
    end else begin
      r_mode    <= w_mode_nxt;
      r_level   <= w_level_nxt;
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
      r_led     <= w_led_nxt;
    end
  end

  always_comb begin
    w_mode_nxt  = r_mode;
    w_level_nxt = r_level;
    if (w_key_press[0]) w_mode_nxt  = mode_next(r_mode);
    if (w_key_press[1]) w_level_nxt = r_level + 2'd1;
  end

  // Threshold needs one extra bit so the top level reaches the full period.
  always_comb begin
    w_thresh = (PWM_W + 1)'((32'(r_level) + 32'd1) * QUARTER);
    w_pwm_on = ({1'b0, r_pwm_cnt} < w_thresh);
  end

  always_comb begin
    w_led_nxt                   = 4'b0000;
    w_led_nxt[LED_BLUE:LED_RED] = mode_mask(r_mode) & {3{w_pwm_on}};
    w_led_nxt[LED_KEY]          = w_key_level[0] | w_key_level[1];
  end

  assign LED = r_led;

endmodule

// File: tb/tb_three_color_light_ctrl.sv
// Randomised and directed checks of colour stepping, PWM duty, debounce and reset.
module tb_three_color_light_ctrl;

  localparam int DB  = 20;
  localparam int PWM = 256;

  logic       Sys_CLK;
  logic       Sys_RST;
  logic [1:0] Key;
  logic [3:0] LED;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: colour index into the sequence, brightness level 0..3.
  int m_mode  = 0;
  int m_level = 3;
  int mask_tab [5] = '{0, 1, 2, 4, 7};

  three_color_light_ctrl #(.DEBOUNCE_CYCLES(DB), .PWM_PERIOD(PWM)) dut (
    .Sys_CLK (Sys_CLK),
    .Sys_RST (Sys_RST),
    .Key     (Key),
    .LED     (LED)
  );

  initial begin
    Sys_CLK = 1'b0;
    forever #5 Sys_CLK = ~Sys_CLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge Sys_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_level = 3;
  endtask

  task automatic model_press(input logic [1:0] keys);
    if (keys[0]) m_mode  = (m_mode + 1) % 5;
    if (keys[1]) m_level = (m_level + 1) % 4;
  endtask

  // Count high cycles of each colour bit over one full PWM frame.
  task automatic check_duty(input string tag);
    int cnt [3];
    int key_hi;
    int thr;
    int m;
    cnt    = '{0, 0, 0};
    key_hi = 0;
    for (int c = 0; c < PWM; c++) begin
      for (int b = 0; b < 3; b++) if (LED[b]) cnt[b]++;
      if (LED[3]) key_hi++;
      step(1);
    end
    thr = (m_level + 1) * PWM / 4;
    m   = mask_tab[m_mode];
    for (int b = 0; b < 3; b++)
      check($sformatf("%s_duty_b%0d", tag, b), cnt[b], m[b] ? thr : 0);
    check($sformatf("%s_keyfb_idle", tag), key_hi, 0);
  endtask

  task automatic press(input logic [1:0] keys, input int hold);
    Key = Key | keys;
    step(hold);
    check("keyfb_held", LED[3], 1);
    Key = Key & ~keys;
    step(DB + 10);
    check("keyfb_released", LED[3], 0);
    model_press(keys);
  endtask

  task automatic glitch(input int idx, input int len);
    Key[idx] = 1'b1;
    step(len);
    Key[idx] = 1'b0;
    step(DB + 10);
  endtask

  task automatic do_reset(input int cycles);
    Sys_RST = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      check("led_in_reset", LED, 0);
    end
    Sys_RST = 1'b0;
    model_reset();
  endtask

  initial begin
    int any_on;
    int r;
    Sys_RST = 1'b1;
    Key     = 2'b00;

    // Reset and idle.
    do_reset(5);
    any_on = 0;
    for (int i = 0; i < 300; i++) begin
      if (LED != 4'b0000) any_on++;
      step(1);
    end
    check("idle_after_reset", any_on, 0);

    // Colour sequence at full brightness, wrapping back to OFF.
    for (int p = 0; p < 5; p++) begin
      press(2'b01, DB + 30);
      check_duty($sformatf("seq%0d", p));
    end

    // Short glitch ignored; bouncing edge gives exactly one step.
    glitch(0, DB - 2);
    check_duty("glitch");
    for (int t = 0; t < 10; t++) begin
      Key[0] = ~Key[0];
      step(3);
    end
    press(2'b01, DB + 30);
    check_duty("bounce");

    // Long hold: no auto-repeat.
    press(2'b01, 8 * DB);
    check_duty("long_hold");

    // Brightness sweep in RED.
    while (m_mode != 1) press(2'b01, DB + 15);
    for (int l = 0; l < 4; l++) begin
      press(2'b10, DB + 15);
      check_duty($sformatf("bright%0d", l));
    end

    // Randomised mix of presses, dual presses and glitches.
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: press(2'b01, DB + 10 + $urandom_range(0, 40));
        1: press(2'b10, DB + 10 + $urandom_range(0, 40));
        2: glitch($urandom_range(0, 1), $urandom_range(1, DB - 2));
        default: press(2'b11, DB + 10 + $urandom_range(0, 40));
      endcase
      check_duty($sformatf("rand%0d", i));
    end

    // Reset mid PWM frame from BLUE at level 1.
    while (m_mode != 3) press(2'b01, DB + 12);
    while (m_level != 1) press(2'b10, DB + 12);
    check_duty("blue_l1");
    step($urandom_range(10, 200));
    Sys_RST = 1'b1;
    step(1);
    check("led_next_edge_reset", LED, 0);
    do_reset(3);
    check_duty("post_reset");
    press(2'b01, DB + 20);
    check_duty("red_full_after_reset");

    // Key held through reset is accepted as a new press afterwards.
    Key[0] = 1'b1;
    step(DB / 2);
    do_reset(3);
    step(DB + 10);
    check("held_through_reset_fb", LED[3], 1);
    Key[0] = 1'b0;
    step(DB + 10);
    model_press(2'b01);
    check_duty("held_through_reset");

    // Simultaneous press from OFF/level 3.
    do_reset(2);
    press(2'b11, DB + 25);
    check_duty("simultaneous");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
